fifo_reader: RTL

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_reader.sv | 117 +++++++++++
 1 files changed

// File: rtl/fifo_reader.sv
// fifo_reader: pulls bytes from a registered-output FIFO into a 2-entry
// in-order buffer and presents them as a valid/ready byte stream.
`default_nettype none

module fifo_reader #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic             fifo_full,
    input  logic             fifo_wr,
    input  logic [7:0]       fifo_dout,
    output logic             fifo_rd,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [7:0]       m_data,
    output logic             busy,
    output logic [CNT_W-1:0] rd_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_STOP = 2'd2;

    logic [1:0] state;
    logic [1:0] state_nx;
    logic       pending;
    logic [1:0] occ;
    logic [7:0] head_byte;
    logic [7:0] tail_byte;
    logic       accepted;
    logic       push;
    logic       pop;

    // A FIFO write in the same cycle wins over our read, so the read only
    // counts when no un-blocked write collides with it.
    assign accepted = fifo_rd && !fifo_empty && !(fifo_wr && !fifo_full);
    assign push     = pending;
    assign pop      = m_valid && m_ready;
    assign m_data   = head_byte;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (enable) state_nx = S_RUN;
            S_RUN:  if (!enable) state_nx = S_STOP;
            S_STOP: begin
                if (enable) begin
                    state_nx = S_RUN;
                end else if (!pending && (occ == 2'd0)) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        fifo_rd = (state == S_RUN) && !fifo_empty
                  && (({1'b0, occ} + {2'b00, pending}) < 3'd2);
        m_valid = (occ != 2'd0);
        busy    = pending || (occ != 2'd0);
    end

    // Buffer: head_byte is always the oldest entry; tail_byte only holds
    // data when occ==2.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending   <= 1'b0;
            occ       <= 2'd0;
            head_byte <= 8'h00;
            tail_byte <= 8'h00;
            rd_count  <= '0;
        end else begin
            pending <= accepted;
            if (pop) begin
                rd_count <= rd_count + CNT_W'(1);
            end
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        head_byte <= fifo_dout;
                    end else begin
                        tail_byte <= fifo_dout;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head_byte <= tail_byte;
                    occ       <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        head_byte <= fifo_dout;
                    end else begin
                        head_byte <= tail_byte;
                        tail_byte <= fifo_dout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
